// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, phase encodings and pipeline types.
// Imported by the phase counter, the top level and the bench.
package vga_pkg;

    localparam int PIX_W = 10;
    localparam int RGB_W = 12;

    localparam int   DEF_CLK_DIV  = 4;
    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_SYNC_POL = 1'b0;

    function automatic int phase_total(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = phase_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = phase_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_e;

    // Stage-1 view of one pixel: everything the DAC side sees for it.
    typedef struct packed {
        logic             active;
        logic             h_sync;
        logic             v_sync;
        logic             frame_start;
        logic [RGB_W-1:0] rgb;
    } stage1_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side bundle between the timing controller and the image memory / DAC.
// master = timing controller, slave = memory plus display consumer.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic [RGB_W-1:0] rgb;
    logic [PIX_W-1:0] pixel_x;
    logic [PIX_W-1:0] pixel_y;
    logic             h_sync;
    logic             v_sync;
    logic [3:0]       Red;
    logic [3:0]       Green;
    logic [3:0]       Blue;
    logic             frame_start;

    modport master (
        input  rgb,
        output pixel_x, pixel_y, h_sync, v_sync, Red, Green, Blue, frame_start
    );

    modport slave (
        output rgb,
        input  pixel_x, pixel_y, h_sync, v_sync, Red, Green, Blue, frame_start
    );

endinterface

// File: rtl/vga_phase_cnt.sv
// One display axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// Both advance only when i_step is high; o_last flags the final position.
module vga_phase_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    output logic [PIX_W-1:0] o_cnt,
    output phase_e           o_phase,
    output logic             o_last
);

    localparam int TOTAL = phase_total(ACTIVE, FP, SYNC, BP);

    localparam logic [PIX_W-1:0] LAST_ACTIVE = PIX_W'(ACTIVE - 1);
    localparam logic [PIX_W-1:0] LAST_FP     = PIX_W'(ACTIVE + FP - 1);
    localparam logic [PIX_W-1:0] LAST_SYNC   = PIX_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [PIX_W-1:0] LAST_POS    = PIX_W'(TOTAL - 1);

    logic [PIX_W-1:0] r_cnt;
    phase_e           r_phase;
    logic             w_last;

    assign w_last = (r_cnt == LAST_POS);

    // NOTE: state is written with <= so every register samples pre-edge values;
    // blocking here would let the phase case see the already-incremented count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_phase <= PH_ACTIVE;
        end else if (i_step) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            // Each phase ends on its last position, so the FSM and r_cnt move together.
            case (r_phase)
                PH_ACTIVE: if (r_cnt == LAST_ACTIVE) r_phase <= PH_FP;
                PH_FP:     if (r_cnt == LAST_FP)     r_phase <= PH_SYNC;
                PH_SYNC:   if (r_cnt == LAST_SYNC)   r_phase <= PH_BP;
                PH_BP:     if (w_last)               r_phase <= PH_ACTIVE;
                default:                             r_phase <= PH_ACTIVE;
            endcase
        end
    end

    assign o_cnt   = r_cnt;
    assign o_phase = r_phase;
    assign o_last  = w_last;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel-tick divider, H/V phase counters, memory addressing
// (stage 0) and a registered colour/sync stage aligned one tick behind the address.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_ctrl_if.master vga
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam stage1_t S1_RESET = '{
        active:      1'b0,
        h_sync:      ~SYNC_POL,
        v_sync:      ~SYNC_POL,
        frame_start: 1'b0,
        rgb:         '0
    };

    logic [DIV_W-1:0] r_div;
    logic             w_pix_tick;

    // With CLK_DIV=1 the counter is stuck at 0 and every clk is a tick.
    assign w_pix_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_div <= '0;
        else      r_div <= w_pix_tick ? '0 : r_div + 1'b1;
    end

    logic [PIX_W-1:0] w_h_cnt;
    logic [PIX_W-1:0] w_v_cnt;
    phase_e           w_h_phase;
    phase_e           w_v_phase;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_v_step;

    assign w_v_step = w_pix_tick & w_h_last;

    vga_phase_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_pix_tick),
        .o_cnt   (w_h_cnt),
        .o_phase (w_h_phase),
        .o_last  (w_h_last)
    );

    vga_phase_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_v_step),
        .o_cnt   (w_v_cnt),
        .o_phase (w_v_phase),
        .o_last  (w_v_last)
    );

    logic w_active0;
    assign w_active0 = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

    // NOTE: defaults come first so every path assigns both outputs; a missing
    // else on a combinational output would infer a latch.
    always_comb begin
        vga.pixel_x = '0;
        vga.pixel_y = '0;
        if (w_active0) begin
            vga.pixel_x = w_h_cnt;
            vga.pixel_y = w_v_cnt;
        end
    end

    // r_at_origin mirrors "counters at (0,0)" without two wide zero compares.
    logic    r_at_origin;
    stage1_t r_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_at_origin <= 1'b1;
            r_s1        <= S1_RESET;
        end else begin
            r_s1.frame_start <= w_pix_tick & r_at_origin;
            if (w_pix_tick) begin
                r_at_origin  <= w_h_last & w_v_last;
                r_s1.active  <= w_active0;
                r_s1.rgb     <= vga.rgb;
                r_s1.h_sync  <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_s1.v_sync  <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vga.Red         = r_s1.active ? r_s1.rgb[11:8] : 4'h0;
    assign vga.Green       = r_s1.active ? r_s1.rgb[7:4]  : 4'h0;
    assign vga.Blue        = r_s1.active ? r_s1.rgb[3:0]  : 4'h0;
    assign vga.h_sync      = r_s1.h_sync;
    assign vga.v_sync      = r_s1.v_sync;
    assign vga.frame_start = r_s1.frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three instances (small geometry, CLK_DIV=1, defaults)
// checked every clk against an arithmetic position model, plus literal timing pins.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    localparam int S_DIV = 2;
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_ctrl_if if_s ();
    vga_timing_ctrl_if if_1 ();
    vga_timing_ctrl_if if_d ();

    vga_timing_ctrl #(
        .CLK_DIV(S_DIV), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b0)
    ) u_small (.clk(clk), .rst(rst), .vga(if_s));

    vga_timing_ctrl #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_div1 (.clk(clk), .rst(rst), .vga(if_1));

    vga_timing_ctrl u_def (.clk(clk), .rst(rst), .vga(if_d));

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    obs_t w_obs_s, w_obs_1, w_obs_d;
    assign w_obs_s = {if_s.pixel_x, if_s.pixel_y, if_s.Red, if_s.Green, if_s.Blue,
                      if_s.h_sync, if_s.v_sync, if_s.frame_start};
    assign w_obs_1 = {if_1.pixel_x, if_1.pixel_y, if_1.Red, if_1.Green, if_1.Blue,
                      if_1.h_sync, if_1.v_sync, if_1.frame_start};
    assign w_obs_d = {if_d.pixel_x, if_d.pixel_y, if_d.Red, if_d.Green, if_d.Blue,
                      if_d.h_sync, if_d.v_sync, if_d.frame_start};

    int total = 0;
    int bad   = 0;
    int t     = 0;   // clk edges since reset release
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // After t edges, t/div ticks have elapsed; the raster position is that count mod
    // the frame size. The DAC side shows the position one tick earlier.
    function automatic obs_t model(input int tt, input int div,
                                   input int ha, input int hf, input int hsl, input int hb,
                                   input int va, input int vf, input int vsl, input int vb,
                                   input logic pol);
        obs_t o;
        int htot, vtot, n, p, h, v, q, qh, qv;
        logic act;
        htot = ha + hf + hsl + hb;
        vtot = va + vf + vsl + vb;
        n = tt / div;
        p = n % (htot * vtot);
        h = p % htot;
        v = p / htot;
        o.px = (h < ha && v < va) ? 10'(h) : 10'd0;
        o.py = (h < ha && v < va) ? 10'(v) : 10'd0;
        if (n == 0) begin
            o.r = 4'd0; o.g = 4'd0; o.b = 4'd0;
            o.hs = ~pol; o.vs = ~pol; o.fs = 1'b0;
        end else begin
            q  = (n - 1) % (htot * vtot);
            qh = q % htot;
            qv = q / htot;
            act = (qh < ha) && (qv < va);
            o.r  = act ? 4'(qh) : 4'd0;
            o.g  = act ? 4'(qv) : 4'd0;
            o.b  = act ? 4'hA   : 4'd0;
            o.hs = (qh >= ha + hf && qh < ha + hf + hsl) ? pol : ~pol;
            o.vs = (qv >= va + vf && qv < va + vf + vsl) ? pol : ~pol;
            o.fs = (tt % div == 0) && (q == 0);
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) t <= 0;
        else      t <= t + 1;
    end

    always @(negedge clk) begin
        check("small", 64'(w_obs_s), 64'(model(t, S_DIV, S_HA, S_HF, S_HS, S_HB,
                                               S_VA, S_VF, S_VS, S_VB, 1'b0)));
        check("div1", 64'(w_obs_1), 64'(model(t, 1, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC,
                                              DEF_H_BP, DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC,
                                              DEF_V_BP, 1'b1)));
        check("def", 64'(w_obs_d), 64'(model(t, DEF_CLK_DIV, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC,
                                             DEF_H_BP, DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC,
                                             DEF_V_BP, 1'b0)));
    end

    // Image memory: rgb scrambled early in every clk, then the true word is presented
    // only ahead of a tick edge, so anything sampled between ticks would show up.
    always @(posedge clk) begin
        #1;
        if_s.rgb = 12'($urandom);
        if_1.rgb = 12'($urandom);
        if_d.rgb = 12'($urandom);
    end

    always @(negedge clk) begin
        if ((t + 1) % S_DIV == 0)
            if_s.rgb = {if_s.pixel_x[3:0], if_s.pixel_y[3:0], 4'hA};
        if_1.rgb = {if_1.pixel_x[3:0], if_1.pixel_y[3:0], 4'hA};
        if ((t + 1) % DEF_CLK_DIV == 0)
            if_d.rgb = {if_d.pixel_x[3:0], if_d.pixel_y[3:0], 4'hA};
    end

    // Edge timestamps for the literal timing pins.
    bit mon_en = 1'b0;
    logic p_s_hs = 1'b1, p_s_vs = 1'b1, p_s_fs = 1'b0;
    logic p_1_hs = 1'b0, p_1_fs = 1'b0;
    logic p_d_hs = 1'b1, p_d_fs = 1'b0;
    int s_hs_on[$], s_hs_off[$], s_vs_on[$], s_vs_off[$], s_fs[$], s_fs_fall[$];
    int o_hs_on[$], o_fs[$];
    int d_hs_on[$], d_hs_off[$], d_fs[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (!if_s.h_sync && p_s_hs) s_hs_on.push_back(cyc);
            if (if_s.h_sync && !p_s_hs) s_hs_off.push_back(cyc);
            if (!if_s.v_sync && p_s_vs) s_vs_on.push_back(cyc);
            if (if_s.v_sync && !p_s_vs) s_vs_off.push_back(cyc);
            if (if_s.frame_start && !p_s_fs) s_fs.push_back(cyc);
            if (!if_s.frame_start && p_s_fs) s_fs_fall.push_back(cyc);
            if (if_1.h_sync && !p_1_hs) o_hs_on.push_back(cyc);
            if (if_1.frame_start && !p_1_fs) o_fs.push_back(cyc);
            if (!if_d.h_sync && p_d_hs) d_hs_on.push_back(cyc);
            if (if_d.h_sync && !p_d_hs) d_hs_off.push_back(cyc);
            if (if_d.frame_start && !p_d_fs) d_fs.push_back(cyc);
        end
        p_s_hs = if_s.h_sync; p_s_vs = if_s.v_sync; p_s_fs = if_s.frame_start;
        p_1_hs = if_1.h_sync; p_1_fs = if_1.frame_start;
        p_d_hs = if_d.h_sync; p_d_fs = if_d.frame_start;
    end

    task automatic check_gap(input string name, input int qa[$], input int ia,
                             input int qb[$], input int ib, input int exp);
        if (ia < qa.size() && ib < qb.size()) begin
            check(name, 64'(qb[ib] - qa[ia]), 64'(exp));
        end else begin
            total++;
            bad++;
            $display("FAIL %s: edge missing, want gap %0d", name, exp);
        end
    endtask

    task automatic wait_pixel_s(input int x, input int y, input string name);
        int n;
        n = 0;
        while (!(if_s.pixel_x == 10'(x) && if_s.pixel_y == 10'(y)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 2000), 64'(1));
    endtask

    initial begin
        int start, n, n_s, n_1, n_d, rx, ry;
        repeat (3 + $urandom_range(0, 3)) @(negedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        start  = cyc;

        // Pixel (5,3) comes back one tick later as R=5, G=3, B=A.
        wait_pixel_s(5, 3, "reach_5_3");
        n = 0;
        while (if_s.pixel_x == 10'd5 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rgb_5_3", 64'({if_s.Red, if_s.Green, if_s.Blue}), 64'(12'h53A));

        n = 0;
        while (if_s.v_sync !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("vblank_rgb", 64'({if_s.Red, if_s.Green, if_s.Blue, if_s.pixel_x}), 64'(0));

        while (cyc - start < 6200) @(negedge clk);
        mon_en = 1'b0;

        // frame_start already carries the one-tick output delay, so sync offsets
        // measured from it are H_ACTIVE+H_FP ticks (line 10 for the small v_sync).
        check_gap("s_line_period", s_hs_on, 0, s_hs_on, 1, 60);
        check_gap("s_hsync_width", s_hs_on, 0, s_hs_off, 0, 12);
        check_gap("s_hsync_from_fs", s_fs, 0, s_hs_on, 0, 40);
        check_gap("s_frame_period", s_fs, 0, s_fs, 1, 900);
        check_gap("s_fs_width", s_fs, 0, s_fs_fall, 0, 1);
        check_gap("s_vsync_width", s_vs_on, 0, s_vs_off, 0, 120);
        check_gap("s_vsync_from_fs", s_fs, 0, s_vs_on, 0, 600);
        check_gap("d_line_period", d_hs_on, 0, d_hs_on, 1, 3200);
        check_gap("d_hsync_width", d_hs_on, 0, d_hs_off, 0, 384);
        check_gap("d_hsync_from_fs", d_fs, 0, d_hs_on, 0, 2624);
        check_gap("div1_line_period", o_hs_on, 0, o_hs_on, 1, 800);
        check_gap("div1_hsync_from_fs", o_fs, 0, o_hs_on, 0, 656);

        // Asynchronous reset in the middle of an active line.
        rx = $urandom_range(2, 14);
        ry = $urandom_range(1, 7);
        wait_pixel_s(rx, ry, "reach_rst_pixel");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_s", 64'(w_obs_s),
              64'(obs_t'{px: 10'd0, py: 10'd0, r: 4'd0, g: 4'd0, b: 4'd0,
                         hs: 1'b1, vs: 1'b1, fs: 1'b0}));
        check("rst_async_1", 64'(w_obs_1), 64'(0));
        repeat ($urandom_range(1, 5)) @(negedge clk);
        #1 rst = 1'b1;

        n_s = 0; n_1 = 0; n_d = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (if_s.frame_start && n_s == 0) n_s = i;
            if (if_1.frame_start && n_1 == 0) n_1 = i;
            if (if_d.frame_start && n_d == 0) n_d = i;
        end
        check("first_fs_small", 64'(n_s), 64'(2));
        check("first_fs_div1", 64'(n_1), 64'(1));
        check("first_fs_def", 64'(n_d), 64'(4));

        repeat (1200) @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
